jac1_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the JAC1 core. It sits between program memory and the decoder and runs each instruction through fetch, decode, execute and write-back phases. It handshakes with a variable-latency program memory and holds the instruction register. It gates the decoder's register, status and program-counter write enables so that architectural state changes only in the write-back cycle. It also provides run/halt/single-step control and a retired-instruction counter.

---
 rtl/jac1_pkg.sv | 19 +
 rtl/jac1_fetch_timer.sv | 28 ++
 rtl/jac1_sequencer.sv | 130 +++++++++++++
 tb/tb_jac1_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jac1_pkg.sv
// Shared JAC1 sequencer types and instruction-field constants.
// The decoder imports the same opcode-field definitions.
package jac1_pkg;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_e;

  localparam int         JAC1_IR_W     = 16;
  localparam int         JAC1_OPC_W    = 5;
  localparam int         JAC1_OPC_MSB  = JAC1_IR_W - 1;
  localparam int         JAC1_OPC_LSB  = JAC1_IR_W - JAC1_OPC_W;
  localparam logic [4:0] JAC1_HALT_OPC = 5'h1F;

endpackage

// File: rtl/jac1_fetch_timer.sv
// Counts FETCH wait cycles; timeout flags the last cycle a fetch may still be acked.
module jac1_fetch_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign timeout = (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/jac1_sequencer.sv
// JAC1 multi-cycle sequencer: fetch/decode/execute/write-back with run, halt,
// single-step, fetch timeout and a retired-instruction counter.
module jac1_sequencer
  import jac1_pkg::*;
#(
  parameter int                       PC_WIDTH      = 8,
  parameter int                       IRWidth       = JAC1_IR_W,
  parameter int                       NumOpCodeBits = JAC1_OPC_W,
  parameter logic [NumOpCodeBits-1:0] HALT_OPCODE   = JAC1_HALT_OPC,
  parameter int                       MEM_TIMEOUT   = 15,
  parameter int                       CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 sys_res,
  input  logic                 run,
  input  logic                 step,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [IRWidth-1:0]   ir_in,
  output logic [IRWidth-1:0]   ir,
  input  logic                 dec_wr_en,
  input  logic                 dec_stat_wr_en,
  input  logic                 dec_cnt_wr_en,
  output logic                 reg_wr_en,
  output logic                 stat_wr_en,
  output logic                 pc_load,
  output logic                 pc_inc,
  output logic                 halted,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  // PC_WIDTH only documents the pairing with the PC block.
  if (PC_WIDTH > 0) begin : g_pc_width_ok
  end

  state_e                 state_q;
  logic                   step_q;
  logic                   mem_err_q;
  logic [IRWidth-1:0]     ir_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   timer_clr;
  logic                   timer_en;
  logic                   timeout;
  logic                   in_wb;

  // Holding the timer clear outside FETCH guarantees it starts at zero on entry.
  assign timer_clr = (state_q != ST_FETCH);
  assign timer_en  = (state_q == ST_FETCH) && !mem_ack;

  jac1_fetch_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .rst    (sys_res),
    .clr    (timer_clr),
    .en     (timer_en),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge sys_res) begin
    if (sys_res) begin
      state_q   <= ST_HALT;
      step_q    <= 1'b0;
      mem_err_q <= 1'b0;
      ir_q      <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (!mem_err_q) begin
            if (run) begin
              state_q <= ST_FETCH;
            end else if (step) begin
              step_q  <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (mem_ack) begin
            ir_q    <= ir_in;
            state_q <= ST_DECODE;
          end else if (timeout) begin
            mem_err_q <= 1'b1;
            step_q    <= 1'b0;
            state_q   <= ST_HALT;
          end
        end
        ST_DECODE: begin
          if (ir_q[IRWidth-1 -: NumOpCodeBits] == HALT_OPCODE) begin
            step_q  <= 1'b0;
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          state_q <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (run && !step_q) begin
            state_q <= ST_FETCH;
          end else begin
            step_q  <= 1'b0;
            state_q <= ST_HALT;
          end
        end
        default: begin
          step_q  <= 1'b0;
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign in_wb      = (state_q == ST_WRITEBACK);
  assign mem_req    = (state_q == ST_FETCH);
  assign halted     = (state_q == ST_HALT);
  assign reg_wr_en  = in_wb && dec_wr_en;
  assign stat_wr_en = in_wb && dec_stat_wr_en;
  assign pc_load    = in_wb && dec_cnt_wr_en;
  assign pc_inc     = in_wb && !dec_cnt_wr_en;
  assign ir         = ir_q;
  assign mem_err    = mem_err_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_jac1_sequencer.sv
// Self-checking bench for jac1_sequencer: per-instruction timing model driven
// by randomized latencies, instruction words and decoder enables.
module tb_jac1_sequencer;

  logic        clk = 1'b0;
  logic        sys_res, run, step, mem_ack;
  logic        dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en;
  logic [15:0] ir_in;

  logic        mem_req, reg_wr_en, stat_wr_en, pc_load, pc_inc, halted, mem_err;
  logic [15:0] ir, instr_cnt;

  logic        w_mem_req, w_reg_wr_en, w_stat_wr_en, w_pc_load, w_pc_inc, w_halted, w_mem_err;
  logic [15:0] w_ir;
  logic [3:0]  w_instr_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  bit exp_halt = 1'b1;

  always #5 clk = ~clk;

  jac1_sequencer dut (
    .clk(clk), .sys_res(sys_res), .run(run), .step(step),
    .mem_req(mem_req), .mem_ack(mem_ack), .ir_in(ir_in), .ir(ir),
    .dec_wr_en(dec_wr_en), .dec_stat_wr_en(dec_stat_wr_en), .dec_cnt_wr_en(dec_cnt_wr_en),
    .reg_wr_en(reg_wr_en), .stat_wr_en(stat_wr_en), .pc_load(pc_load), .pc_inc(pc_inc),
    .halted(halted), .mem_err(mem_err), .instr_cnt(instr_cnt)
  );

  // Narrow counter copy, fed the same stimulus, exposes counter wrap cheaply.
  jac1_sequencer #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .sys_res(sys_res), .run(run), .step(step),
    .mem_req(w_mem_req), .mem_ack(mem_ack), .ir_in(ir_in), .ir(w_ir),
    .dec_wr_en(dec_wr_en), .dec_stat_wr_en(dec_stat_wr_en), .dec_cnt_wr_en(dec_cnt_wr_en),
    .reg_wr_en(w_reg_wr_en), .stat_wr_en(w_stat_wr_en), .pc_load(w_pc_load), .pc_inc(w_pc_inc),
    .halted(w_halted), .mem_err(w_mem_err), .instr_cnt(w_instr_cnt)
  );

  // {mem_err, mem_req, halted, reg_wr_en, stat_wr_en, pc_load, pc_inc}
  function automatic logic [6:0] obs_vec();
    return {mem_err, mem_req, halted, reg_wr_en, stat_wr_en, pc_load, pc_inc};
  endfunction

  task automatic do_reset();
    sys_res = 1'b1; run = 1'b0; step = 1'b0; mem_ack = 1'b0; ir_in = '0;
    dec_wr_en = 1'b0; dec_stat_wr_en = 1'b0; dec_cnt_wr_en = 1'b0;
    @(negedge clk);
    sys_res = 1'b0;
    exp_cnt = 0;
    exp_halt = 1'b1;
    @(negedge clk);
  endtask

  // Entered at a negedge where the DUT shows its first FETCH cycle. lat is the
  // number of unacked FETCH cycles. Leaves at the negedge after the instruction.
  task automatic do_instr(input int lat, input logic [15:0] word, input logic wr,
                          input logic st, input logic cn, input logic stepped,
                          input logic run_after, input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    bit is_halt;
    is_halt = (word[15:11] == 5'h1F);
    dec_wr_en = wr; dec_stat_wr_en = st; dec_cnt_wr_en = cn;
    for (int k = 0; k <= lat; k++) begin
      obs = obs_vec(); exp = 7'b0100000;
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL %s fetch%0d outputs: got %b want %b", tag, k, obs, exp);
      end
      mem_ack = (k == lat);
      ir_in = (k == lat) ? word : 16'($urandom);
      step = 1'($urandom);
      @(negedge clk);
    end
    mem_ack = 1'($urandom); ir_in = 16'($urandom);
    obs = obs_vec();
    tests++;
    if (obs !== 7'b0 || ir !== word) begin
      fails++; $display("FAIL %s decode: outputs %b ir %h want 0000000 ir %h", tag, obs, ir, word);
    end
    @(negedge clk);
    if (is_halt) begin
      obs = obs_vec();
      tests++;
      if (obs !== 7'b0010000 || instr_cnt !== 16'(exp_cnt)) begin
        fails++; $display("FAIL %s halt-op: outputs %b cnt %0d want 0010000 cnt %0d", tag, obs, instr_cnt, exp_cnt);
      end
      run = 1'b0; step = 1'b0; mem_ack = 1'b0;
      exp_halt = 1'b1;
      @(negedge clk);
      return;
    end
    obs = obs_vec();
    tests++;
    if (obs !== 7'b0) begin
      fails++; $display("FAIL %s execute: outputs %b want 0000000", tag, obs);
    end
    mem_ack = 1'($urandom);
    @(negedge clk);
    obs = obs_vec(); exp = {3'b000, wr, st, cn, !cn};
    tests++;
    if (obs !== exp || instr_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL %s writeback: outputs %b cnt %0d want %b cnt %0d", tag, obs, instr_cnt, exp, exp_cnt);
    end
    run = run_after; step = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 65536;
    exp_halt = !(run_after && !stepped);
    tests++;
    if (instr_cnt !== 16'(exp_cnt) || halted !== exp_halt || mem_req !== !exp_halt) begin
      fails++; $display("FAIL %s retire: cnt %0d halted %b req %b want cnt %0d halted %b", tag,
                        instr_cnt, halted, mem_req, exp_cnt, exp_halt);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[15:11] = 5'($urandom_range(0, 30));
    return w;
  endfunction

  task automatic test_reset();
    sys_res = 1'b1; run = 1'b0; step = 1'b0; mem_ack = 1'b0; ir_in = 16'hFFFF;
    dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1; dec_cnt_wr_en = 1'b0;
    #1;
    tests++;
    if (obs_vec() !== 7'b0010000 || ir !== 16'h0 || instr_cnt !== 16'h0) begin
      fails++; $display("FAIL reset: outputs %b ir %h cnt %h want 0010000 0000 0000", obs_vec(), ir, instr_cnt);
    end
    do_reset();
  endtask

  task automatic test_run();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      do_instr(0, rand_word(), 1'($urandom), 1'($urandom), 1'b0, 1'b0, (i < 2), "run");
    tests++;
    if (instr_cnt !== 16'd3) begin
      fails++; $display("FAIL run-count: got %0d want 3", instr_cnt);
    end
  endtask

  task automatic test_step();
    do_reset();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    do_instr(1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "step");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (halted !== 1'b1 || instr_cnt !== 16'd1) begin
        fails++; $display("FAIL step-hold: halted %b cnt %0d want 1 1", halted, instr_cnt);
      end
    end
    // run raised during a stepped instruction must still stop after it
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    do_instr(0, rand_word(), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "step-run");
    run = 1'b0;
  endtask

  task automatic test_cnt_wr();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(2, rand_word(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "jump-a");
    do_instr(0, rand_word(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "jump-b");
  endtask

  task automatic test_halt_opcode();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(0, rand_word(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "pre-halt");
    do_instr(1, 16'hF800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "halt-op");
    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(0, 16'hF800 | 16'($urandom_range(0, 2047)), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "halt-op2");
  endtask

  task automatic test_timeout();
    int req_cycles;
    do_reset();
    run = 1'b1;
    @(negedge clk);
    req_cycles = 0;
    for (int k = 0; k < 20 && mem_req === 1'b1; k++) begin
      req_cycles++;
      mem_ack = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (req_cycles !== 15 || obs_vec() !== 7'b1010000) begin
      fails++; $display("FAIL timeout: req cycles %0d outputs %b want 15 1010000", req_cycles, obs_vec());
    end
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom); step = 1'b1; mem_ack = 1'($urandom);
      @(negedge clk);
      tests++;
      if (obs_vec() !== 7'b1010000) begin
        fails++; $display("FAIL err-sticky%0d: outputs %b want 1010000", i, obs_vec());
      end
    end
    do_reset();
    tests++;
    if (mem_err !== 1'b0 || halted !== 1'b1) begin
      fails++; $display("FAIL err-clear: mem_err %b halted %b want 0 1", mem_err, halted);
    end
  endtask

  task automatic test_ack_last_cycle();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(14, rand_word(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ack-last");
  endtask

  task automatic test_reset_mid_execute();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(0, rand_word(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "pre-rst");
    dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1; dec_cnt_wr_en = 1'b1;
    mem_ack = 1'b1; ir_in = 16'h1234;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    sys_res = 1'b1;
    #1;
    tests++;
    if (obs_vec() !== 7'b0010000 || ir !== 16'h0 || instr_cnt !== 16'h0) begin
      fails++; $display("FAIL rst-exec: outputs %b ir %h cnt %h want 0010000 0000 0000", obs_vec(), ir, instr_cnt);
    end
    @(negedge clk);
    tests++;
    if (obs_vec() !== 7'b0010000) begin
      fails++; $display("FAIL rst-hold: outputs %b want 0010000", obs_vec());
    end
    sys_res = 1'b0; run = 1'b0;
    exp_cnt = 0; exp_halt = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic ra;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (exp_halt) begin
        run = 1'b1;
        @(negedge clk);
      end
      ra = ($urandom_range(0, 3) != 0);
      do_instr($urandom_range(0, 14), rand_word(), 1'($urandom), 1'($urandom), 1'($urandom),
               1'b0, ra, "random");
    end
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      do_instr($urandom_range(0, 3), rand_word(), 1'b0, 1'b0, 1'($urandom), 1'b0, 1'b1, "wrap");
      if (i == 15) begin
        tests++;
        if (w_instr_cnt !== 4'(exp_cnt % 16)) begin
          fails++; $display("FAIL wrap-zero: got %0d want %0d", w_instr_cnt, exp_cnt % 16);
        end
      end
    end
    tests++;
    if (w_instr_cnt !== 4'(exp_cnt % 16) || instr_cnt !== 16'd17) begin
      fails++; $display("FAIL wrap-one: narrow %0d wide %0d want %0d 17", w_instr_cnt, instr_cnt, exp_cnt % 16);
    end
    run = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_run();
    test_step();
    test_cnt_wr();
    test_halt_opcode();
    test_timeout();
    test_ack_last_cycle();
    test_reset_mid_execute();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
